// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
// Definitions shared by the EX-stage arithmetic blocks:
//   - ALU SELECT codes for the RV32M divide group. The alu decodes the same
//     SELECT field, so both blocks take the codes from here.
//   - State encoding for the iterative divider FSM.
//   - isDivOp(): true when a SELECT code belongs to the divide group.
// ---------------------------------------------------------------------------
package div_unit_pkg;

   localparam logic [4:0] ALU_DIV  = 5'b01100;
   localparam logic [4:0] ALU_DIVU = 5'b01101;
   localparam logic [4:0] ALU_REM  = 5'b01110;
   localparam logic [4:0] ALU_REMU = 5'b01111;

   localparam logic [1:0] STATE_IDLE = 2'd0;
   localparam logic [1:0] STATE_CALC = 2'd1;
   localparam logic [1:0] STATE_FIX  = 2'd2;
   localparam logic [1:0] STATE_DONE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = STATE_IDLE,
      S_CALC = STATE_CALC,
      S_FIX  = STATE_FIX,
      S_DONE = STATE_DONE
   } divState_e;

   function automatic logic isDivOp(input logic [4:0] sel);
      return (sel == ALU_DIV) || (sel == ALU_DIVU) ||
             (sel == ALU_REM) || (sel == ALU_REMU);
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// ---------------------------------------------------------------------------
// div_unit_step
// One combinational restoring-division step. It shifts the concatenated
// {remainder, quotient} pair left by one bit. It then subtracts the divisor
// from the partial remainder when that remainder is not smaller than the
// divisor, and records the outcome in the quotient LSB.
// The block can be chained to build a higher-radix divider.
//
// Ports:
//   rem_i     [XLEN:0]   partial remainder (one guard bit for compare/sub)
//   quo_i     [XLEN-1:0] dividend bits still to be consumed / quotient so far
//   divisor_i [XLEN-1:0] divisor magnitude
//   rem_o     [XLEN:0]   next partial remainder
//   quo_o     [XLEN-1:0] next quotient
// ---------------------------------------------------------------------------
module div_unit_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN:0]   rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] divisorExt;
   logic          fits;

   // The partial remainder is always below the divisor, so its top bit is
   // zero. Shifting it left therefore cannot overflow the XLEN+1 bit window.
   always_comb begin
      shifted    = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
      divisorExt = {1'b0, divisor_i};
      fits       = (shifted >= divisorExt);
      rem_o      = fits ? (shifted - divisorExt) : shifted;
      quo_o      = {quo_i[XLEN-2:0], fits};
   end

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU. It sits in the EX
// stage beside the alu.
//
// The operands are converted to magnitudes on entry. The FSM then runs one
// restoring step per cycle for XLEN cycles. The sign is applied to the
// selected result in the FIX state. The result is committed to RESULT in the
// DONE state, together with a registered DONE pulse.
//
// Divide-by-zero and signed overflow are resolved when the request is
// accepted, and the FSM jumps straight to DONE.
//
// Ports:
//   CLK     clock, rising edge
//   RESET   asynchronous active-high reset
//   START   request, accepted only while idle
//   FLUSH   synchronous abort; drops an operation without a DONE
//   SELECT  ALU op code (DIV/DIVU/REM/REMU)
//   DATA1   dividend (rs1)
//   DATA2   divisor (rs2)
//   RESULT  registered quotient/remainder, held until the next DONE
//   BUSY    high while an operation is in progress, including the DONE pulse
//   DONE    one-cycle pulse; RESULT is valid in that cycle
// ---------------------------------------------------------------------------
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic            FLUSH,
   input  logic [4:0]      SELECT,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   output logic [XLEN-1:0] RESULT,
   output logic            BUSY,
   output logic            DONE
);

   localparam int CW = $clog2(XLEN);

   divState_e       state_q,   state_d;
   logic            isRem_q,   isRem_d;
   logic            negRes_q,  negRes_d;
   logic [XLEN:0]   rem_q,     rem_d;
   logic [XLEN-1:0] quo_q,     quo_d;
   logic [XLEN-1:0] divisor_q, divisor_d;
   logic [CW-1:0]   count_q,   count_d;
   logic [XLEN-1:0] res_q,     res_d;
   logic [XLEN-1:0] result_q,  result_d;
   logic            done_q,    done_d;

   logic [XLEN:0]   stepRem;
   logic [XLEN-1:0] stepQuo;
   logic            signedOp;
   logic            remOp;
   logic            sign1;
   logic            sign2;
   logic            overflowCase;
   logic [XLEN-1:0] magnitude;

   // Single restoring step applied to the current iteration state.
   div_unit_step #(
      .XLEN(XLEN)
   ) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (divisor_q),
      .rem_o     (stepRem),
      .quo_o     (stepQuo)
   );

   // Operation decode, from the live SELECT/DATA inputs. These signals only
   // matter in IDLE, when a request is accepted.
   always_comb begin
      signedOp     = (SELECT == ALU_DIV) || (SELECT == ALU_REM);
      remOp        = (SELECT == ALU_REM) || (SELECT == ALU_REMU);
      sign1        = signedOp & DATA1[XLEN-1];
      sign2        = signedOp & DATA2[XLEN-1];
      overflowCase = signedOp && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (DATA2 == {XLEN{1'b1}});
      magnitude    = isRem_q ? rem_q[XLEN-1:0] : quo_q;
   end

   // Next-state and datapath control.
   //
   // The final value is staged in res_q and copied to RESULT only when the
   // DONE state completes without a flush. This way, an aborted operation
   // never disturbs the value the pipeline last saw.
   //
   // done_q keeps the pulse one cycle behind the DONE state. While done_q is
   // high, a new request is refused, so START in the DONE cycle is ignored.
   always_comb begin
      state_d   = state_q;
      isRem_d   = isRem_q;
      negRes_d  = negRes_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      count_d   = count_q;
      res_d     = res_q;
      result_d  = result_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START && !FLUSH && !done_q && isDivOp(SELECT)) begin
               isRem_d   = remOp;
               negRes_d  = remOp ? sign1 : (sign1 ^ sign2);
               rem_d     = '0;
               quo_d     = sign1 ? (-DATA1) : DATA1;
               divisor_d = sign2 ? (-DATA2) : DATA2;
               count_d   = CW'(XLEN - 1);
               if (DATA2 == '0) begin
                  res_d   = remOp ? DATA1 : {XLEN{1'b1}};
                  state_d = S_DONE;
               end else if (overflowCase) begin
                  res_d   = remOp ? '0 : DATA1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end

         S_CALC: begin
            if (FLUSH) begin
               state_d = S_IDLE;
            end else begin
               rem_d   = stepRem;
               quo_d   = stepQuo;
               count_d = count_q - CW'(1);
               if (count_q == '0) begin
                  state_d = S_FIX;
               end
            end
         end

         S_FIX: begin
            if (FLUSH) begin
               state_d = S_IDLE;
            end else begin
               res_d   = negRes_q ? (-magnitude) : magnitude;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            if (!FLUSH) begin
               result_d = res_q;
               done_d   = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, all cleared asynchronously by RESET.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         isRem_q   <= 1'b0;
         negRes_q  <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         count_q   <= '0;
         res_q     <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         isRem_q   <= isRem_d;
         negRes_q  <= negRes_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         count_q   <= count_d;
         res_q     <= res_d;
         result_q  <= result_d;
         done_q    <= done_d;
      end
   end

   assign RESULT = result_q;
   assign DONE   = done_q;
   assign BUSY   = (state_q != S_IDLE) || done_q;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Directed bench for div_unit. Each accepted request pushes its reference
// result onto a queue, and every DONE pulse pops and compares it.
// Inputs are driven, and outputs sampled, on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_div_unit;
   import div_unit_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        START;
   logic        FLUSH;
   logic [4:0]  SELECT;
   logic [31:0] DATA1;
   logic [31:0] DATA2;
   logic [31:0] RESULT;
   logic        BUSY;
   logic        DONE;

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] expQ[$];
   logic [31:0] lastResult = 32'h0;

   always #5 CLK = ~CLK;

   div_unit #(.XLEN(32)) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .START  (START),
      .FLUSH  (FLUSH),
      .SELECT (SELECT),
      .DATA1  (DATA1),
      .DATA2  (DATA2),
      .RESULT (RESULT),
      .BUSY   (BUSY),
      .DONE   (DONE)
   );

   // Reference model: truncating RV32M semantics, including the zero-divisor
   // and overflow results.
   function automatic logic [31:0] modelDiv(input logic [4:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      logic ovf;
      logic [31:0] r;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r = 32'h0;
      case (sel)
         ALU_DIV:  r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
         ALU_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         ALU_REM:  r = (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
         ALU_REMU: r = (b == 0) ? a : a % b;
         default:  r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic bit isSpecial(input logic [4:0] sel,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
      return (b == 0) ||
             (((sel == ALU_DIV) || (sel == ALU_REM)) &&
              (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [31:0] exp;
      if (expQ.size() == 0) begin
         compared++;
         mismatched++;
         $error("[TB] FAIL %s: DONE observed=1 expected=0 (no pending result)", tag);
      end else begin
         exp = expQ.pop_front();
         checkVal(tag, RESULT, exp);
         lastResult = exp;
      end
   endtask

   // Issues one request so that START is sampled at edge 0. Cycle k is the
   // falling edge after edge k.
   //   flushAt    >= 0: FLUSH is sampled at that edge; no result is expected.
   //   midStartAt >= 0: a stray DIVU 50/5 START is sampled at that edge.
   task automatic applyStimulus(input string tag, input logic [4:0] sel,
                                input logic [31:0] a, input logic [31:0] b,
                                input int expLat, input int flushAt,
                                input int midStartAt);
      logic [31:0] prior;
      int lat;
      int busyCycles;
      prior      = lastResult;
      lat        = -1;
      busyCycles = 0;
      if (flushAt < 0) expQ.push_back(modelDiv(sel, a, b));
      SELECT = sel;
      DATA1  = a;
      DATA2  = b;
      START  = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (BUSY) busyCycles++;
         if (DONE) begin
            if (lat < 0) lat = k;
            checkOutput(tag);
         end
         if (k == flushAt) checkVal({tag, " busy after flush"}, {31'b0, BUSY}, 32'h0);
         if (flushAt < 0 && lat >= 0 && !BUSY) break;
         FLUSH = (k + 1 == flushAt);
         START = (k + 1 == midStartAt);
         if (k + 1 == midStartAt) begin
            SELECT = ALU_DIVU;
            DATA1  = 32'd50;
            DATA2  = 32'd5;
         end
         @(negedge CLK);
      end
      FLUSH = 1'b0;
      START = 1'b0;
      if (flushAt >= 0) begin
         checkVal({tag, " result held"}, RESULT, prior);
      end else begin
         checkVal({tag, " latency"}, 32'(lat), 32'(expLat));
         if (expLat > 1) checkVal({tag, " busy cycles"}, 32'(busyCycles), 32'(expLat + 1));
         checkVal({tag, " idle after"}, {31'b0, BUSY}, 32'h0);
      end
   endtask

   initial begin
      logic [4:0]  rSel;
      logic [31:0] rA;
      logic [31:0] rB;
      RESET  = 1'b1;
      START  = 1'b0;
      FLUSH  = 1'b0;
      SELECT = 5'b0;
      DATA1  = 32'h0;
      DATA2  = 32'h0;
      repeat (2) @(negedge CLK);
      checkVal("reset RESULT", RESULT, 32'h0);
      checkVal("reset BUSY", {31'b0, BUSY}, 32'h0);
      checkVal("reset DONE", {31'b0, DONE}, 32'h0);
      RESET = 1'b0;
      @(negedge CLK);

      applyStimulus("DIVU ffffffff/1", ALU_DIVU, 32'hFFFF_FFFF, 32'h1, 34, -1, -1);
      applyStimulus("DIV -7/2",        ALU_DIV,  32'hFFFF_FFF9, 32'h2, 34, -1, -1);
      applyStimulus("REM -7/2",        ALU_REM,  32'hFFFF_FFF9, 32'h2, 34, -1, -1);
      applyStimulus("DIV 5/0",         ALU_DIV,  32'h5, 32'h0, 1, -1, -1);
      applyStimulus("REMU 5/0",        ALU_REMU, 32'h5, 32'h0, 1, -1, -1);
      applyStimulus("DIV ovf",         ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, -1, -1);
      applyStimulus("REM ovf",         ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, -1, -1);
      applyStimulus("DIVU start in done", ALU_DIVU, 32'd9, 32'd3, 34, -1, 35);

      for (int i = 0; i < 4; i++) begin
         rSel = ALU_DIV + 5'($urandom_range(0, 3));
         rA   = $urandom;
         rB   = $urandom >> $urandom_range(0, 31);
         applyStimulus("random op", rSel, rA, rB, isSpecial(rSel, rA, rB) ? 1 : 34, -1, -1);
      end

      // Non-divide SELECT, and FLUSH together with START, must not start.
      SELECT = 5'b00000;
      START  = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      checkVal("bad select ignored", {31'b0, BUSY}, 32'h0);
      SELECT = ALU_DIVU;
      START  = 1'b1;
      FLUSH  = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      FLUSH = 1'b0;
      checkVal("flush beats start", {31'b0, BUSY}, 32'h0);

      applyStimulus("DIVU 100/7 flushed", ALU_DIVU, 32'd100, 32'd7, 34, 10, -1);
      applyStimulus("REMU 100/7",         ALU_REMU, 32'd100, 32'd7, 34, -1, 5);

      // Asynchronous reset partway through a DIV.
      SELECT = ALU_DIV;
      DATA1  = 32'd1000;
      DATA2  = 32'd3;
      START  = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      repeat (14) @(negedge CLK);
      RESET = 1'b1;
      #1;
      checkVal("async reset BUSY", {31'b0, BUSY}, 32'h0);
      checkVal("async reset DONE", {31'b0, DONE}, 32'h0);
      checkVal("async reset RESULT", RESULT, 32'h0);
      @(negedge CLK);
      RESET = 1'b0;
      lastResult = 32'h0;
      @(negedge CLK);
      applyStimulus("DIV 3/2", ALU_DIV, 32'd3, 32'd2, 34, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU operations. It sits in the EX stage beside the combinational alu and takes the same DATA1/DATA2/SELECT operands from the ID/EX register. It returns RESULT to the EX result mux and holds BUSY high so the hazard unit stalls the pipeline.

Parameters:
XLEN, 32, operand/result width; only 32 is verified.

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  request; sampled only in IDLE
FLUSH  input  1  synchronous abort (branch mispredict/trap)
SELECT  input  5  01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU
DATA1  input  XLEN  dividend (rs1)
DATA2  input  XLEN  divisor (rs2)
RESULT  output  XLEN  quotient or remainder, registered
BUSY  output  1  high whenever state != IDLE
DONE  output  1  one-cycle pulse; RESULT valid in that cycle

Behaviour:
- Reset, asynchronous: state=IDLE, RESULT=0, BUSY=0, DONE=0, and all internal registers cleared. Reset asserted mid-operation aborts immediately, with no DONE.
- States: IDLE, CALC, FIX, DONE.
- IDLE: if START=1 and SELECT is in 01100..01111:
  - Latch the operation.
  - Latch |DATA1| and |DATA2| (signed ops) or the raw values (unsigned ops).
  - Latch the result sign: quotient sign = s1^s2, remainder sign = s1.
  - Go to CALC with counter=31.
  - START with any other SELECT is ignored.
- Special cases, detected in IDLE at START; the next state is DONE directly, giving a 1-cycle latency:
  - divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> DATA1.
  - DIV/REM with DATA1=0x80000000, DATA2=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- CALC: one restoring step per cycle.
  - Compute {rem,quo} shift-left-1; if rem>=divisor, subtract and set quo[0].
  - Decrement the counter; after the step with counter==0, go to FIX.
  - 32 CALC cycles in total.
- FIX: select quotient or remainder, negate if the latched sign requires it, register RESULT, go to DONE.
- DONE: DONE=1 for exactly this cycle, BUSY still 1, then go to IDLE. A START seen during the DONE cycle is ignored.
- Latency, normal path: START sampled at edge 0; CALC runs edges 1..32; FIX edge 33; DONE is high in the cycle after edge 34. BUSY is high from after edge 0 through the DONE cycle, i.e. 35 cycles.
- Latency, special path: DONE is high in the cycle after edge 1.
- RESULT holds its value after DONE until the next DONE. It is not cleared by START.
- START while BUSY=1 is ignored; the operands are not re-latched.
- FLUSH=1 in any non-IDLE state: go to IDLE at the next edge, DONE not asserted, RESULT unchanged.
  - FLUSH has priority over START in IDLE: the request is not accepted.
  - FLUSH coincident with the DONE cycle: DONE is still seen, because the pulse is already present.
- Width rules:
  - Remainder register is XLEN+1 bits for the compare/subtract.
  - Negation is two's complement modulo 2^XLEN.
  - Quotient/remainder sign fixups match the RISC-V spec: truncating division; the remainder takes the dividend's sign.

Decomposition:
- Shared package (the same one the alu uses) holds:
  - ALU SELECT code localparams (ALU_DIV=01100, ALU_DIVU=01101, ALU_REM=01110, ALU_REMU=01111), shared with alu to avoid divergence.
  - State encoding localparams for IDLE/CALC/FIX/DONE.
- One natural sub-module: div_step, combinational. It takes {rem, quo, divisor} and returns the next {rem, quo}. It is reused if an unrolled radix-4 version is built later.

Test Plan:
- DIVU DATA1=0xFFFFFFFF, DATA2=0x00000001, START pulse -> DONE in the cycle after edge 34, RESULT=0xFFFFFFFF; BUSY high 35 cycles, then low.
- DIV DATA1=0xFFFFFFF9 (-7), DATA2=0x00000002 -> RESULT=0xFFFFFFFD (-3); REM with the same operands -> RESULT=0xFFFFFFFF (-1).
- DIV 5/0 -> RESULT=0xFFFFFFFF and REMU 5/0 -> RESULT=0x00000005, each with DONE in the cycle after edge 1.
- DIV 0x80000000/0xFFFFFFFF -> RESULT=0x80000000; REM with the same operands -> 0x00000000; each with 1-cycle latency.
- Start DIVU 100/7, then:
  - FLUSH at edge 10 -> IDLE, no DONE, RESULT keeps its prior value.
  - Re-START REMU 100/7 -> RESULT=0x00000002.
  - A second START pulsed mid-operation is ignored.
- Assert RESET asynchronously at cycle 15 of a DIV -> BUSY, DONE and RESULT go to 0 immediately. After release, DIV 3/2 -> RESULT=0x00000001.
